// File: rtl/reorg_inverse_mover.sv
// reorg_inverse_mover: depth-to-space data mover (inverse stride-2 reorg).
// Reads a WIDTH_SRC x HEIGHT_SRC x DEPTH_SRC tensor and writes it as a
// WIDTH x HEIGHT x DEPTH tensor, walking the destination in write order.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start, hold         transfer request (IDLE only), read backpressure
//   busy, done          transfer in progress, one-cycle completion pulse
//   rd_en/rd_addr       source read request; rd_data returns RD_LAT later
//   wr_en/wr_addr/wr_data  destination write (wr_data passes rd_data through)
module reorg_inverse_mover #(
  parameter int unsigned WIDTH_SRC  = 12,
  parameter int unsigned HEIGHT_SRC = 12,
  parameter int unsigned DEPTH_SRC  = 256,
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned HEIGHT     = 24,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned STRIDE     = 2,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_SZ    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               hold,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [ADDR_SZ-1:0] rd_addr,
  input  logic [DATA_W-1:0]  rd_data,
  output logic               wr_en,
  output logic [ADDR_SZ-1:0] wr_addr,
  output logic [DATA_W-1:0]  wr_data
);

  localparam int unsigned XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned CW = (DEPTH  > 1) ? $clog2(DEPTH)  : 1;
  // Source channels belonging to one spatial offset inside a stride block.
  localparam int unsigned CH_PER_OFF = DEPTH_SRC / (STRIDE * STRIDE);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_e;

  state_e             state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [CW-1:0]      c_q, c_d;
  logic               rd_en_q, rd_en_d;
  logic [ADDR_SZ-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_SZ-1:0] rd_waddr_q, rd_waddr_d;
  logic               rd_last_q, rd_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               vld_q   [RD_LAT];
  logic               last_q  [RD_LAT];
  logic [ADDR_SZ-1:0] waddr_q [RD_LAT];

  logic [ADDR_SZ-1:0] map_rd_addr, map_wr_addr;
  logic               cnt_last;
  logic               issue;
  logic               wr_last;

  // Address mapping for the element the counters point at.
  always_comb begin : addr_map
    logic [ADDR_SZ-1:0] xa, ya, off, cs;
    xa  = ADDR_SZ'(x_q);
    ya  = ADDR_SZ'(y_q);
    off = (ya % ADDR_SZ'(STRIDE)) * ADDR_SZ'(STRIDE) + (xa % ADDR_SZ'(STRIDE));
    cs  = off * ADDR_SZ'(CH_PER_OFF) + ADDR_SZ'(c_q);
    map_rd_addr = xa / ADDR_SZ'(STRIDE)
                + ADDR_SZ'(WIDTH_SRC) * (ya / ADDR_SZ'(STRIDE) + cs * ADDR_SZ'(HEIGHT_SRC));
    map_wr_addr = xa + ADDR_SZ'(WIDTH) * (ya + ADDR_SZ'(c_q) * ADDR_SZ'(HEIGHT));
  end

  assign cnt_last = (x_q == XW'(WIDTH - 1)) && (y_q == YW'(HEIGHT - 1))
                 && (c_q == CW'(DEPTH - 1));
  assign wr_last  = vld_q[RD_LAT-1] && last_q[RD_LAT-1];

  // Next-state, read issue and counter advance.
  always_comb begin : fsm_next
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    c_d        = c_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_waddr_d = rd_waddr_q;
    rd_last_d  = 1'b0;
    issue      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          issue   = !hold;
        end
      end
      RUN: begin
        // The last read is on the bus this cycle: nothing left to issue.
        if (rd_en_q && rd_last_q) state_d = DRAIN;
        else                      issue   = !hold;
      end
      DRAIN: begin
        if (wr_last) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue) begin
      rd_en_d    = 1'b1;
      rd_addr_d  = map_rd_addr;
      rd_waddr_d = map_wr_addr;
      rd_last_d  = cnt_last;
      // x fastest, then y, then c; wraps to zero after the final element.
      if (x_q == XW'(WIDTH - 1)) begin
        x_d = '0;
        if (y_q == YW'(HEIGHT - 1)) begin
          y_d = '0;
          c_d = (c_q == CW'(DEPTH - 1)) ? '0 : c_q + CW'(1);
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  // Control and read-side registers.
  always_ff @(posedge clk or negedge reset_n) begin : ctrl_regs
    if (!reset_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      c_q        <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_waddr_q <= '0;
      rd_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      c_q        <= c_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      rd_waddr_q <= rd_waddr_d;
      rd_last_q  <= rd_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Write-address delay line, aligned with read data RD_LAT cycles later.
  always_ff @(posedge clk or negedge reset_n) begin : wr_pipe
    if (!reset_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        vld_q[i]   <= 1'b0;
        last_q[i]  <= 1'b0;
        waddr_q[i] <= '0;
      end
    end else begin
      vld_q[0]   <= rd_en_q;
      last_q[0]  <= rd_en_q && rd_last_q;
      waddr_q[0] <= rd_waddr_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i]   <= vld_q[i-1];
        last_q[i]  <= last_q[i-1];
        waddr_q[i] <= waddr_q[i-1];
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = vld_q[RD_LAT-1];
  assign wr_addr = waddr_q[RD_LAT-1];
  // No buffering: read data goes straight to the write port, zero when idle.
  assign wr_data = wr_en ? rd_data : '0;

endmodule

// File: tb/tb_reorg_inverse_mover.sv
// Bench for reorg_inverse_mover: instance A (RD_LAT=1) covers reset, mapping,
// throughput and data; instance B (RD_LAT=3) covers backpressure, latency and
// start-while-busy. Expected writes are queued when reads are seen.
module tb_reorg_inverse_mover;

  localparam int N     = 36864;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        a_start, a_hold, a_busy, a_done, a_rd_en, a_wr_en;
  logic [15:0] a_rd_addr, a_rd_data, a_wr_addr, a_wr_data;
  logic        b_start, b_hold, b_busy, b_done, b_rd_en, b_wr_en;
  logic [15:0] b_rd_addr, b_rd_data, b_wr_addr, b_wr_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reorg_inverse_mover #(.RD_LAT(LAT_A)) u_dut_a (
    .clk(clk), .reset_n(rst_n), .start(a_start), .hold(a_hold),
    .busy(a_busy), .done(a_done), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .rd_data(a_rd_data), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data));

  reorg_inverse_mover #(.RD_LAT(LAT_B)) u_dut_b (
    .clk(clk), .reset_n(rst_n), .start(b_start), .hold(b_hold),
    .busy(b_busy), .done(b_done), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data));

  // Source memories holding data == address, with fixed read latency.
  logic [15:0] a_dl [LAT_A];
  logic [15:0] b_dl [LAT_B];
  always @(posedge clk) begin
    a_dl[0] <= a_rd_en ? a_rd_addr : 16'hDEAD;
    for (int i = 1; i < LAT_A; i++) a_dl[i] <= a_dl[i-1];
    b_dl[0] <= b_rd_en ? b_rd_addr : 16'hDEAD;
    for (int i = 1; i < LAT_B; i++) b_dl[i] <= b_dl[i-1];
  end
  assign a_rd_data = a_dl[LAT_A-1];
  assign b_rd_data = b_dl[LAT_B-1];

  // Source address of destination element n (write order x, y, c).
  function automatic int exp_rd(int n);
    int x, y, c, off, cs;
    x   = n % 24;
    y   = (n / 24) % 24;
    c   = n / 576;
    off = (y % 2) * 2 + (x % 2);
    cs  = off * 64 + c;
    return x / 2 + 12 * (y / 2 + cs * 12);
  endfunction

  task automatic test_reset();
    int n;
    int bad;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", a_busy); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", a_done); end
    checks++; if (a_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b, expected 0", a_rd_en); end
    checks++; if (a_rd_addr !== 16'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d, expected 0", a_rd_addr); end
    checks++; if (a_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b, expected 0", a_wr_en); end
    checks++; if (a_wr_addr !== 16'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d, expected 0", a_wr_addr); end
    checks++; if (a_wr_data !== 16'd0) begin errors++; $display("FAIL reset_wr_data: got %0d, expected 0", a_wr_data); end
    checks++;
    if ({b_busy, b_done, b_rd_en, b_wr_en, b_rd_addr, b_wr_addr, b_wr_data} !== 52'd0) begin
      errors++; $display("FAIL reset_b_outputs: got %b %b %b %b, expected all zero", b_busy, b_done, b_rd_en, b_wr_en);
    end
    rst_n = 1'b1;
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL reset_first_busy: got %b, expected 1", a_busy); end
    checks++; if (a_rd_en !== 1'b1 || a_rd_addr !== 16'd0) begin
      errors++; $display("FAIL reset_first_read: got en=%b addr=%0d, expected en=1 addr=0", a_rd_en, a_rd_addr);
    end
    n = 0;
    for (int k = 0; k < 3000 && n < 1000; k++) begin
      if (a_rd_en) n++;
      @(negedge clk);
    end
    checks++; if (n < 1000) begin errors++; $display("FAIL reset_run_timeout: got %0d reads, expected 1000", n); end
    // Asynchronous reset in the middle of a clock cycle.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_busy, a_done, a_rd_en, a_wr_en, a_rd_addr, a_wr_addr, a_wr_data} !== 52'd0) begin
      errors++; $display("FAIL reset_async_clear: got busy=%b done=%b rd_en=%b wr_en=%b rd_addr=%0d wr_addr=%0d wr_data=%0d, expected all 0",
                         a_busy, a_done, a_rd_en, a_wr_en, a_rd_addr, a_wr_addr, a_wr_data);
    end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (a_wr_en !== 1'b0 || a_busy !== 1'b0) bad++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (a_wr_en !== 1'b0 || a_rd_en !== 1'b0 || a_busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL reset_quiet_after: got %0d active cycles, expected 0", bad); end
  endtask

  task automatic test_mapping();
    int q_wa[$]; int q_wd[$]; int q_cy[$];
    int sample_n[8] = '{0, 1, 2, 3, 24, 25, 576, 36863};
    int sample_a[8] = '{0, 9216, 1, 9217, 18432, 27648, 144, 36863};
    int n_rd, n_wr, n_done, s, c, ewa, ewd, ecy;
    bit fin;
    n_rd = 0; n_wr = 0; n_done = 0; fin = 1'b0;
    @(negedge clk); a_hold = 1'b0; a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    s = cyc;
    for (int k = 0; k < 40000 && !fin; k++) begin
      c = cyc - s;
      checks++; if (a_busy !== (c <= N + LAT_A)) begin errors++; $display("FAIL map_busy c=%0d: got %b, expected %b", c, a_busy, c <= N + LAT_A); end
      checks++; if (a_rd_en !== (c < N)) begin errors++; $display("FAIL map_rd_en c=%0d: got %b, expected %b", c, a_rd_en, c < N); end
      if (a_rd_en) begin
        checks++; if (a_rd_addr !== 16'(exp_rd(n_rd))) begin errors++; $display("FAIL map_rd_addr n=%0d: got %0d, expected %0d", n_rd, a_rd_addr, exp_rd(n_rd)); end
        for (int i = 0; i < 8; i++) begin
          if (n_rd == sample_n[i]) begin
            checks++; if (a_rd_addr !== 16'(sample_a[i])) begin errors++; $display("FAIL map_sample n=%0d: got %0d, expected %0d", n_rd, a_rd_addr, sample_a[i]); end
          end
        end
        q_wa.push_back(n_rd); q_wd.push_back(exp_rd(n_rd)); q_cy.push_back(c + LAT_A);
        n_rd++;
      end
      if (a_wr_en) begin
        checks++;
        if (q_wa.size() == 0) begin
          errors++; $display("FAIL map_unexpected_write c=%0d: got addr=%0d, expected no write", c, a_wr_addr);
        end else begin
          ewa = q_wa.pop_front(); ewd = q_wd.pop_front(); ecy = q_cy.pop_front();
          if (a_wr_addr !== 16'(ewa)) begin errors++; $display("FAIL map_wr_addr c=%0d: got %0d, expected %0d", c, a_wr_addr, ewa); end
          checks++; if (a_wr_data !== 16'(ewd)) begin errors++; $display("FAIL map_wr_data addr=%0d: got %0d, expected %0d", ewa, a_wr_data, ewd); end
          checks++; if (c != ecy) begin errors++; $display("FAIL map_wr_cycle addr=%0d: got %0d, expected %0d", ewa, c, ecy); end
        end
        n_wr++;
      end
      if (a_done) begin
        n_done++;
        checks++; if (c != N + LAT_A) begin errors++; $display("FAIL map_done_cycle: got %0d, expected %0d", c, N + LAT_A); end
      end
      if (n_done > 0 && c >= N + LAT_A + 2) fin = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!fin) begin errors++; $display("FAIL map_timeout: got no completion, expected done"); end
    checks++; if (n_wr != N) begin errors++; $display("FAIL map_write_count: got %0d, expected %0d", n_wr, N); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL map_done_count: got %0d, expected 1", n_done); end
    checks++; if (q_wa.size() != 0) begin errors++; $display("FAIL map_pending: got %0d, expected 0", q_wa.size()); end
  endtask

  task automatic test_backpressure_latency();
    int q_wa[$]; int q_wd[$]; int q_cy[$];
    int n_rd, n_wr, n_done, s, c, ewa, ewd, ecy;
    int m_iss, stalls, forced, done_c;
    bit fin, pend, restarted;
    n_rd = 0; n_wr = 0; n_done = 0; fin = 1'b0; restarted = 1'b0;
    stalls = 0; forced = 0; done_c = -1;
    @(negedge clk); b_hold = 1'b0; b_start = 1'b1;
    m_iss = 1; pend = 1'b1;
    @(negedge clk); b_start = 1'b0;
    s = cyc;
    for (int k = 0; k < 70000 && !fin; k++) begin
      c = cyc - s;
      checks++; if (b_rd_en !== pend) begin errors++; $display("FAIL bp_rd_en c=%0d: got %b, expected %b", c, b_rd_en, pend); end
      if (b_done) begin n_done++; done_c = c; end
      checks++; if (b_busy !== !(n_done > 0 && c > done_c)) begin
        errors++; $display("FAIL bp_busy c=%0d: got %b, expected %b", c, b_busy, !(n_done > 0 && c > done_c));
      end
      if (b_done) begin
        checks++; if (c != N - 1 + stalls + LAT_B + 1) begin
          errors++; $display("FAIL bp_done_cycle: got %0d, expected %0d (stalls %0d)", c, N + stalls + LAT_B, stalls);
        end
      end
      if (b_rd_en) begin
        checks++; if (b_rd_addr !== 16'(exp_rd(n_rd))) begin errors++; $display("FAIL bp_rd_addr n=%0d: got %0d, expected %0d", n_rd, b_rd_addr, exp_rd(n_rd)); end
        q_wa.push_back(n_rd); q_wd.push_back(exp_rd(n_rd)); q_cy.push_back(c + LAT_B);
        n_rd++;
      end
      if (b_wr_en) begin
        checks++;
        if (q_wa.size() == 0) begin
          errors++; $display("FAIL bp_unexpected_write c=%0d: got addr=%0d, expected no write", c, b_wr_addr);
        end else begin
          ewa = q_wa.pop_front(); ewd = q_wd.pop_front(); ecy = q_cy.pop_front();
          if (b_wr_addr !== 16'(ewa)) begin errors++; $display("FAIL bp_wr_addr c=%0d: got %0d, expected %0d", c, b_wr_addr, ewa); end
          checks++; if (b_wr_data !== 16'(ewd)) begin errors++; $display("FAIL bp_wr_data addr=%0d: got %0d, expected %0d", ewa, b_wr_data, ewd); end
          checks++; if (c != ecy) begin errors++; $display("FAIL bp_wr_lag addr=%0d: got cycle %0d, expected %0d", ewa, c, ecy); end
        end
        n_wr++;
      end
      // Second start while busy, once element 500 has been read.
      b_start = (n_rd >= 500) && !restarted;
      if (b_start) restarted = 1'b1;
      b_hold = ($urandom_range(99, 0) < 30);
      if (m_iss == N - 1 && forced < 2) begin b_hold = 1'b1; forced++; end
      pend = (m_iss < N) && !b_hold;
      if (m_iss < N) begin
        if (b_hold) stalls++;
        else        m_iss++;
      end
      if (n_done > 0 && c >= done_c + 3) fin = 1'b1;
      else @(negedge clk);
    end
    b_hold = 1'b0; b_start = 1'b0;
    checks++; if (!fin) begin errors++; $display("FAIL bp_timeout: got no completion, expected done"); end
    checks++; if (n_wr != N) begin errors++; $display("FAIL bp_write_count: got %0d, expected %0d", n_wr, N); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL bp_done_count: got %0d, expected 1", n_done); end
    checks++; if (q_wa.size() != 0) begin errors++; $display("FAIL bp_pending: got %0d, expected 0", q_wa.size()); end
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; a_hold = 1'b0;
    b_start = 1'b0; b_hold = 1'b0;
    test_reset();
    fork
      test_mapping();
      test_backpressure_latency();
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reorg_inverse_mover.md
# reorg_inverse_mover

Depth-to-space (inverse reorg) data mover. It reads a 12x12x256 tensor from the source feature buffer and writes it as a 24x24x64 tensor to the destination buffer, undoing the stride-2 space-to-depth reorg. It sits between the feature memories and the layer sequencer: it owns the read port of the source buffer and the write port of the destination buffer while busy, and tolerates a fixed read latency and sequencer backpressure.

## Interface
- WIDTH_SRC, 12, source tensor width
- HEIGHT_SRC, 12, source tensor height
- DEPTH_SRC, 256, source channels; must equal DEPTH*STRIDE*STRIDE
- WIDTH, 24, destination width (= WIDTH_SRC*STRIDE)
- HEIGHT, 24, destination height (= HEIGHT_SRC*STRIDE)
- DEPTH, 64, destination channels
- STRIDE, 2, reorg stride (only 2 supported)
- RD_LAT, 1, source read latency in cycles (1..4)
- DATA_W, 16, element width
- Address width is `ADDR_SZ from parameters.h (>=16)
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a transfer; ignored unless IDLE
- hold  in  1  backpressure; while 1 no new read is issued
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final write
- rd_en  out  1  source read strobe
- rd_addr  out  `ADDR_SZ  source element address
- rd_data  in  DATA_W  source data, valid RD_LAT cycles after rd_en
- wr_en  out  1  destination write strobe
- wr_addr  out  `ADDR_SZ  destination element address
- wr_data  out  DATA_W  destination data

## Operation
- States: IDLE, RUN, DRAIN, FINISH. IDLE->RUN on start. RUN->DRAIN in the cycle the last read issues. DRAIN->FINISH when the last in-flight write is emitted. FINISH->IDLE after one cycle, with done=1 in FINISH.
- Iteration covers the destination tensor in write order: x fastest (0..WIDTH-1), then y, then c. The counters are registered and advance only on an issued read (RUN && !hold).
- Mapping per element: off = (y%2)*2 + (x%2); cs = off*DEPTH + c; rd_addr = x/2 + WIDTH_SRC*(y/2 + cs*HEIGHT_SRC); wr_addr = x + WIDTH*(y + c*HEIGHT).
- Arithmetic is unsigned at full `ADDR_SZ width with no truncation. Because of the write order, wr_addr increments by 1 per element from 0 to WIDTH*HEIGHT*DEPTH-1.
- Pipeline: wr_addr is delayed through an RD_LAT-deep shift register tagged with a valid bit. wr_en = delayed valid, and wr_data = rd_data in the same cycle. There is no data buffering.
- hold stops only new reads. In-flight reads still complete and write on schedule, and hold never drops or duplicates an element.
- A start pulse while not IDLE is ignored and does not restart the transfer.
- Async reset mid-transfer returns the block to IDLE and clears all counters and pipeline valids. No write follows reset.

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0.
- start sampled at edge T0: busy=1 and the first rd_en=1 with rd_addr=0 in cycle T0+1.
- With hold=0 throughout, reads issue back-to-back from T0+1 to T0+36864, with one read per cycle.
- The write for a read issued in cycle t appears in cycle t+RD_LAT.
- The last write occurs at T0+36864+RD_LAT. done pulses in the next cycle, busy falls with done, and the block returns to IDLE.
- Every hold cycle during RUN extends completion by exactly one cycle.
- rd_en is low in DRAIN, FINISH and IDLE.

## Test plan
- Reset: assert reset_n=0 mid-run (element ~1000) -> all outputs 0 on the same cycle, no further wr_en, a new start runs a full transfer from rd_addr 0.
- Mapping: start, RD_LAT=1, hold=0 -> first rd_addr values 0, 9216, 1, 9217, ...; at y=1: 18432, 27648; at c=1 start: 144; last rd_addr 36863; wr_addr values 0..36863 in order.
- Throughput and done: RD_LAT=1 -> exactly 36864 wr_en pulses, done at T0+36866 for one cycle, busy high T0+1..T0+36866.
- Data integrity: source model holds data = address -> each write has wr_data equal to the expected rd_addr for that wr_addr, with no gaps or duplicates.
- Backpressure: random 30% hold, including hold during the final read -> still 36864 writes, correct order, completion delayed by the number of hold cycles seen in RUN.
- Latency and start-while-busy: RD_LAT=3 with start pulsed again at element 500 -> the second start is ignored, writes lag reads by exactly 3 cycles, and done occurs once.
